// File: rtl/tmds_serializer_pn_if.sv
// rtl/tmds_serializer_pn_if.sv - word handshake between TMDS encoders and the serializer
interface tmds_serializer_pn_if #(
  parameter int C_channels = 4
);
  logic [10*C_channels-1:0] in_word;
  logic                     in_valid;
  logic                     in_ready;

  modport master (output in_word, output in_valid, input in_ready);
  modport slave  (input in_word, input in_valid, output in_ready);
endinterface

// File: rtl/tmds_serializer_pn.sv
// rtl/tmds_serializer_pn.sv - TMDS word serializer with registered p/n outputs
module tmds_serializer_pn #(
  parameter int                    C_channels = 4,
  parameter int                    C_ddr      = 0,
  parameter logic [C_channels-1:0] C_invert   = '0,
  parameter logic [9:0]            C_idle     = 10'b1101010100
) (
  input  logic                          i_clk_shift,
  input  logic                          i_reset,
  input  logic                          i_enable,
  tmds_serializer_pn_if.slave           s_in,
  output logic [(C_ddr+1)*C_channels-1:0] o_out_p,
  output logic [(C_ddr+1)*C_channels-1:0] o_out_n,
  output logic                          o_underflow,
  input  logic                          i_underflow_clr
);
  localparam int         L   = C_ddr + 1;
  localparam int         K   = 10 / L;
  localparam logic [3:0] KM1 = 4'(K - 1);
  localparam int         OW  = L * C_channels;

  logic [3:0]    r_cnt;
  logic [9:0]    r_shreg [C_channels];
  logic [OW-1:0] r_out_p;
  logic [OW-1:0] r_out_n;
  logic          r_underflow;

  logic          w_slot;
  logic          w_take;
  logic [OW-1:0] w_bits;

  // The last count of a word is the load slot; every channel reloads together there.
  assign w_slot        = (r_cnt == KM1);
  assign w_take        = i_enable & s_in.in_valid;
  assign s_in.in_ready = w_slot & i_enable & ~i_reset;

  // Gather the low L bits of each channel's shift register, polarity-adjusted per channel.
  always_comb begin
    w_bits = '0;
    for (int c = 0; c < C_channels; c++) begin
      for (int l = 0; l < L; l++) begin
        w_bits[L*c+l] = r_shreg[c][l] ^ C_invert[c];
      end
    end
  end

  // Word cadence, shifting, output registers and sticky underflow flag.
  always_ff @(posedge i_clk_shift) begin
    if (i_reset) begin
      r_cnt       <= KM1;
      r_out_p     <= '0;
      r_out_n     <= '1;
      r_underflow <= 1'b0;
      for (int c = 0; c < C_channels; c++) begin
        r_shreg[c] <= C_idle;
      end
    end else begin
      r_out_p <= w_bits;
      r_out_n <= ~w_bits;
      if (w_slot) begin
        r_cnt <= 4'd0;
        for (int c = 0; c < C_channels; c++) begin
          r_shreg[c] <= w_take ? s_in.in_word[10*c +: 10] : C_idle;
        end
      end else begin
        r_cnt <= r_cnt + 4'd1;
        for (int c = 0; c < C_channels; c++) begin
          r_shreg[c] <= r_shreg[c] >> L;
        end
      end
      // A missed word outranks a coincident clear so no underflow event is lost.
      if (w_slot && i_enable && !s_in.in_valid) begin
        r_underflow <= 1'b1;
      end else if (i_underflow_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_out_p     = r_out_p;
  assign o_out_n     = r_out_n;
  assign o_underflow = r_underflow;
endmodule
